// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frogger_pkg
// Description : Shared coordinate widths, screen bounds, lane FSM state
//               encoding and speed-per-level helper for the Frogger lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package frogger_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    localparam int SCREEN_X_MIN = 20;
    localparam int SCREEN_X_MAX = 640;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    // Pixels per movement step: 1x, 2x, then 3x base from level 2 upward.
    function automatic logic [10:0] speed_for_level(input logic [2:0]  lvl,
                                                    input logic [10:0] base);
        if (lvl == 3'd0) begin
            return base;
        end else if (lvl == 3'd1) begin
            return base << 1;
        end else begin
            return base + (base << 1);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Clock-enable divider. Counts 0..DIV-1 while enabled and
//               raises tick combinationally on the cycle whose edge wraps it.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Clear beats enable, so a lane dropping to idle never emits a wrap tick.
    assign tick = en && !clr && (cnt == LAST);

    // Divider counter: clear, else advance/wrap while enabled, else hold.
    always_ff @(posedge clk_in) begin
        if (!reset_in || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_traffic.sv
`default_nettype none
// ============================================================================
// Module      : lane_traffic
// Description : N-car horizontal lane generator with level-dependent speed,
//               configurable direction and edge wrap-around; outputs packed
//               bounding boxes for rendering and collision checking.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_traffic
    import frogger_pkg::*;
#(
    parameter int NUM_CARS   = 3,
    parameter int TICK_DIV   = 15000000,
    parameter int DIR        = 0,
    parameter int X_MIN      = SCREEN_X_MIN,
    parameter int X_MAX      = SCREEN_X_MAX,
    parameter int CAR_W      = 60,
    parameter int LANE_T     = 110,
    parameter int LANE_H     = 40,
    parameter int SPACING    = 200,
    parameter int SPEED_BASE = 20
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      run,
    input  logic                      freeze,
    input  logic [2:0]                level,
    output logic [X_W*NUM_CARS-1:0]   car_l,
    output logic [X_W*NUM_CARS-1:0]   car_r,
    output logic [Y_W*NUM_CARS-1:0]   car_t,
    output logic [Y_W*NUM_CARS-1:0]   car_b,
    output logic                      moving,
    output logic                      step
);

    localparam logic [10:0] L_MIN = 11'(X_MIN);
    localparam logic [10:0] L_MAX = 11'(X_MAX - CAR_W);

    generate
        if (X_MIN + (NUM_CARS - 1) * SPACING > X_MAX - CAR_W) begin : g_bad_layout
            $error("lane_traffic: initial layout does not fit the playfield");
        end
    endgenerate

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        tick;
    logic        tick_en;
    logic        tick_clr;
    logic [10:0] speed;

    assign tick_en  = (state == ST_RUN);
    assign tick_clr = ~run;
    assign speed    = speed_for_level(level, 11'(SPEED_BASE));

    // Next state: run low always forces idle; otherwise freeze picks RUN/FROZEN.
    always_comb begin
        state_nxt = ST_IDLE;
        if (run) begin
            state_nxt = freeze ? ST_FROZEN : ST_RUN;
        end
    end

    // State register plus registered status outputs.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state  <= ST_IDLE;
            moving <= 1'b0;
            step   <= 1'b0;
        end else begin
            state  <= state_nxt;
            moving <= (state_nxt == ST_RUN);
            step   <= tick;
        end
    end

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .en       (tick_en),
        .clr      (tick_clr),
        .tick     (tick)
    );

    generate
        for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
            localparam logic [X_W-1:0] INIT_L = X_W'(X_MIN + i * SPACING);
            localparam logic [X_W-1:0] INIT_R = X_W'(X_MIN + i * SPACING + CAR_W);

            logic [X_W-1:0] l_q;
            logic [X_W-1:0] r_q;
            logic [10:0]    l_ext;
            logic [X_W-1:0] l_nxt;

            assign l_ext = {1'b0, l_q};

            // Candidate position, compared at 11 bits so the sum cannot wrap.
            always_comb begin
                l_nxt = l_q;
                if (DIR == 0) begin
                    if (l_ext + speed > L_MAX) begin
                        l_nxt = X_W'(L_MIN);
                    end else begin
                        l_nxt = X_W'(l_ext + speed);
                    end
                end else begin
                    if (l_ext < L_MIN + speed) begin
                        l_nxt = X_W'(L_MAX);
                    end else begin
                        l_nxt = X_W'(l_ext - speed);
                    end
                end
            end

            // Car position: initial layout in reset/idle, advance on each tick.
            always_ff @(posedge clk_in) begin
                if (!reset_in || !run) begin
                    l_q <= INIT_L;
                    r_q <= INIT_R;
                end else if (tick) begin
                    l_q <= l_nxt;
                    r_q <= l_nxt + X_W'(CAR_W);
                end
            end

            assign car_l[X_W*i +: X_W] = l_q;
            assign car_r[X_W*i +: X_W] = r_q;
            assign car_t[Y_W*i +: Y_W] = Y_W'(LANE_T);
            assign car_b[Y_W*i +: Y_W] = Y_W'(LANE_T + LANE_H);
        end
    endgenerate

endmodule
`default_nettype wire
